// File: rtl/slow_clk_monitor.sv
// Measures the high and low phase lengths of an asynchronous slow clock in clk cycles,
// reporting period, duty balance, liveness and a stuck-level timeout.
module slow_clk_monitor #(
  parameter int              CNT_W   = 32,
  parameter longint unsigned TIMEOUT = 300_000_000,
  parameter longint unsigned TOL     = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W:0]   period,
  output logic             duty_ok,
  output logic             valid,
  output logic             alive,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] ea;
    logic [CNT_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]       fill_q, fill_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_time_q, high_time_d, low_time_q, low_time_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             duty_ok_q, duty_ok_d, valid_q, valid_d;
  logic             alive_q, alive_d, timeout_q, timeout_d;
  logic             rise, fall, sync_ready, cnt_at_limit;

  assign rise         = s2_q & ~s3_q;
  assign fall         = ~s2_q & s3_q;
  assign cnt_at_limit = (cnt_q == TIMEOUT_C);
  // s2 only carries a genuine sample of slow_clk two edges after reset; before
  // that its reset 0 must not count as "seen low", or a partial high phase gets measured.
  assign sync_ready   = fill_q[1];

  always_comb begin
    s1_d        = slow_clk;
    s2_d        = s1_q;
    s3_d        = s2_q;
    fill_d      = sync_ready ? fill_q : fill_q + 2'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_lat_d    = hi_lat_q;
    high_time_d = high_time_q;
    low_time_d  = low_time_q;
    period_d    = period_q;
    duty_ok_d   = duty_ok_q;
    valid_d     = 1'b0;
    alive_d     = alive_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_ready && !s2_q) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          cnt_d   = ONE_C;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = ONE_C;
          state_d  = LOW;
        end else if (cnt_at_limit) begin
          timeout_d = 1'b1;
          alive_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LOW: begin
        if (rise) begin
          high_time_d = hi_lat_q;
          low_time_d  = cnt_q;
          period_d    = {1'b0, hi_lat_q} + {1'b0, cnt_q};
          duty_ok_d   = (abs_diff(hi_lat_q, cnt_q) <= TOL_C);
          valid_d     = 1'b1;
          alive_d     = 1'b1;
          cnt_d       = ONE_C;
          state_d     = HIGH;
        end else if (cnt_at_limit) begin
          timeout_d = 1'b1;
          alive_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      fill_q      <= 2'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_lat_q    <= '0;
      high_time_q <= '0;
      low_time_q  <= '0;
      period_q    <= '0;
      duty_ok_q   <= 1'b0;
      valid_q     <= 1'b0;
      alive_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_lat_q    <= hi_lat_d;
      high_time_q <= high_time_d;
      low_time_q  <= low_time_d;
      period_q    <= period_d;
      duty_ok_q   <= duty_ok_d;
      valid_q     <= valid_d;
      alive_q     <= alive_d;
      timeout_q   <= timeout_d;
    end
  end

  assign high_time = high_time_q;
  assign low_time  = low_time_q;
  assign period    = period_q;
  assign duty_ok   = duty_ok_q;
  assign valid     = valid_q;
  assign alive     = alive_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with CNT_W=16, TIMEOUT=64, TOL=2.
module tb_slow_clk_monitor;

  logic        clk;
  logic        rst_n;
  logic        slow_clk;
  logic [15:0] high_time;
  logic [15:0] low_time;
  logic [16:0] period;
  logic        duty_ok;
  logic        valid;
  logic        alive;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt  = 0;
  int tcnt  = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int tcyc  = 0;
  int c0, v0, t0;

  slow_clk_monitor #(.CNT_W(16), .TIMEOUT(64), .TOL(2)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk),
    .high_time(high_time), .low_time(low_time), .period(period),
    .duty_ok(duty_ok), .valid(valid), .alive(alive), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcnt      <= vcnt + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
    end
    if (timeout) begin
      tcnt <= tcnt + 1;
      tcyc <= cyc;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Holds slow_clk at lvl for n rising edges; entered and left at 1 time unit past an edge.
  task automatic phase(input logic lvl, input int n);
    slow_clk = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_meas(input string tag, input int hi, input int lo, input int dok);
    chk({tag, "_high"},   high_time, hi);
    chk({tag, "_low"},    low_time,  lo);
    chk({tag, "_period"}, period,    hi + lo);
    chk({tag, "_duty"},   duty_ok,   dok);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    slow_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_meas("rst", 0, 0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_alive", alive, 0);
    chk("rst_timeout", timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 10/10 toggling from a low start
    phase(0, 6); phase(1, 10); phase(0, 10);
    c0 = cyc; v0 = vcnt;
    phase(1, 10);
    chk("t1_vcnt", vcnt - v0, 1);
    chk("t1_latency", last_vcyc - c0, 3);
    chk_meas("t1", 10, 10, 1);
    chk("t1_alive", alive, 1);
    phase(0, 10); phase(1, 10);
    chk("t1_vcnt2", vcnt - v0, 2);
    chk("t1_spacing", last_vcyc - prev_vcyc, 20);

    // duty boundary: 11/9 passes, 12/7 fails
    phase(0, 10); phase(1, 11); phase(0, 9); phase(1, 12);
    chk_meas("t2a", 11, 9, 1);
    phase(0, 7); phase(1, 10);
    chk_meas("t2b", 12, 7, 0);

    // stuck high -> timeout, outputs hold, re-arm needs low + two rises
    phase(0, 10);
    c0 = cyc; v0 = vcnt; t0 = tcnt;
    phase(1, 100);
    chk("t3_tcnt", tcnt - t0, 1);
    chk("t3_tlat", tcyc - c0, 67);
    chk("t3_vcnt", vcnt - v0, 1);
    chk("t3_alive", alive, 0);
    chk_meas("t3_hold", 10, 10, 1);
    phase(0, 10); phase(1, 10); phase(0, 10);
    chk("t3_rearm_novalid", vcnt - v0, 1);
    phase(1, 10);
    chk("t3_rearm_valid", vcnt - v0, 2);
    chk("t3_alive2", alive, 1);

    // reset while slow_clk high: partial high phase never reported
    slow_clk = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_alive", alive, 0);
    chk("t4_rst_high", high_time, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    v0 = vcnt;
    phase(1, 8); phase(0, 10); phase(1, 10); phase(0, 10);
    chk("t4_novalid", vcnt - v0, 0);
    phase(1, 10);
    chk("t4_vcnt", vcnt - v0, 1);
    chk_meas("t4", 10, 10, 1);

    // reset in the middle of a low phase
    phase(0, 5);
    rst_n = 1'b0;
    #1;
    chk_meas("t5_rst", 0, 0, 0);
    chk("t5_rst_alive", alive, 0);
    phase(0, 3);
    rst_n = 1'b1;
    v0 = vcnt;
    phase(0, 5); phase(1, 10); phase(0, 10);
    chk("t5_novalid", vcnt - v0, 0);
    phase(1, 10);
    chk("t5_vcnt", vcnt - v0, 1);
    chk_meas("t5", 10, 10, 1);

    // 1-cycle high pulses every 6 cycles
    v0 = vcnt;
    phase(0, 5);
    repeat (4) begin
      phase(1, 1);
      phase(0, 5);
    end
    chk("t6_vcnt", vcnt - v0, 4);
    chk("t6_spacing", last_vcyc - prev_vcyc, 6);
    chk_meas("t6", 1, 5, 0);

    // a 64-cycle phase ends on the edge, which beats the timeout
    t0 = tcnt;
    phase(1, 64); phase(0, 10); phase(1, 10);
    chk("t7_tcnt", tcnt - t0, 0);
    chk_meas("t7", 64, 10, 0);
    chk("t7_alive", alive, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
